// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA pixel-timing generator.
// Defaults describe 640x480 @ 60 Hz.
package vga_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   localparam int unsigned DEF_H_TOTAL = h_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int unsigned DEF_V_TOTAL = v_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
   localparam int unsigned H_W         = $clog2(DEF_H_TOTAL);
   localparam int unsigned V_W         = $clog2(DEF_V_TOTAL);

endpackage

// File: rtl/vga_axis_cnt.sv
// Single-axis timing counter: counts 0..TOTAL-1 while enabled and decodes
// the visible region and the (polarity-free) sync window from the count.
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter int unsigned W      = $clog2(h_total(ACTIVE, FP, SYNC, BP))
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output logic         active,
   output logic         sync
);

   localparam int unsigned TOTAL = h_total(ACTIVE, FP, SYNC, BP);
   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   // Widened copy so the sync end bound may equal TOTAL without overflowing W bits.
   logic [31:0] cnt_ext;
   assign cnt_ext = 32'(cnt);

   assign wrap   = en && (cnt == LAST);
   assign active = cnt_ext < ACTIVE;
   assign sync   = (cnt_ext >= ACTIVE + FP) && (cnt_ext < ACTIVE + FP + SYNC);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/vga_timing.sv
// VGA pixel-timing generator driven by a one-cycle pixel strobe on the system clock.
// Define VGA_TIMING_REG_OUT_EN to register sync/active/coordinate outputs (one-pixel lag).
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pix_en_i,
   output logic hsync_o,
   output logic vsync_o,
   output logic active_o,
   output logic [$clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP))-1:0] x_o,
   output logic [$clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))-1:0] y_o,
   output logic line_start_o,
   output logic frame_start_o
);

   localparam int unsigned XW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int unsigned YW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

   logic [XW-1:0] h_cnt;
   logic [YW-1:0] v_cnt;
   logic          h_wrap;
   logic          unused_v_wrap;
   logic          h_active;
   logic          v_active;
   logic          h_sync;
   logic          v_sync;
   logic          hs_lvl;
   logic          vs_lvl;

   vga_axis_cnt #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .W      (XW)
   ) u_h (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (pix_en_i),
      .cnt    (h_cnt),
      .wrap   (h_wrap),
      .active (h_active),
      .sync   (h_sync)
   );

   // h_wrap already carries the strobe, so the vertical axis steps once per line.
   vga_axis_cnt #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .W      (YW)
   ) u_v (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (h_wrap),
      .cnt    (v_cnt),
      .wrap   (unused_v_wrap),
      .active (v_active),
      .sync   (v_sync)
   );

   assign hs_lvl = h_sync ? HS_POL : ~HS_POL;
   assign vs_lvl = v_sync ? VS_POL : ~VS_POL;

   assign line_start_o  = pix_en_i && (h_cnt == '0);
   assign frame_start_o = line_start_o && (v_cnt == '0);

`ifdef VGA_TIMING_REG_OUT_EN
   // Capture the pre-update decode on each strobe so all five pins stay aligned.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync_o  <= ~HS_POL;
         vsync_o  <= ~VS_POL;
         active_o <= 1'b1;
         x_o      <= '0;
         y_o      <= '0;
      end else if (pix_en_i) begin
         hsync_o  <= hs_lvl;
         vsync_o  <= vs_lvl;
         active_o <= h_active && v_active;
         x_o      <= h_cnt;
         y_o      <= v_cnt;
      end
   end
`else
   assign hsync_o  = hs_lvl;
   assign vsync_o  = vs_lvl;
   assign active_o = h_active && v_active;
   assign x_o      = h_cnt;
   assign y_o      = v_cnt;
`endif

endmodule
